// File: rtl/ex_muldiv.sv
// Iterative 32-bit unsigned multiply (shift-add) / divide (restoring) unit for the EX stage.
// One iteration per cycle; results land in HI/LO on entry to DONE.
module ex_muldiv (
    input  logic        reloj,
    input  logic        resetEX,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  rd_i,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [4:0]  rd_o,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic        op_div_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [63:0] prod, prod_nxt;
    logic [32:0] sum;
    logic [31:0] rem, rem_nxt;
    logic [31:0] quo, quo_nxt;
    logic [32:0] shifted, diff;
    logic        op_ok, accept, div_zero;

    assign op_ok    = (op == 2'b01) || (op == 2'b10);
    assign accept   = (state == IDLE) && start && op_ok && !flush;
    assign div_zero = (op == 2'b10) && (B == '0);

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stall = busy || ((state == IDLE) && start && op_ok);

    // One multiply step and one divide step; only the one matching op_div_q is used.
    always_comb begin
        sum      = {1'b0, prod[63:32]} + {1'b0, a_q};
        prod_nxt = prod[0] ? {sum, prod[31:1]} : {1'b0, prod[63:1]};
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, b_q};
        if (!diff[32]) begin
            rem_nxt = diff[31:0];
            quo_nxt = {quo[30:0], 1'b1};
        end else begin
            rem_nxt = shifted[31:0];
            quo_nxt = {quo[30:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = div_zero ? DONE : BUSY;
                BUSY:    if (cnt == 5'd31) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge reloj) begin
        if (!resetEX) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge reloj) begin
        if (!resetEX) begin
            cnt      <= '0;
            HI       <= '0;
            LO       <= '0;
            rd_o     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_div_q <= 1'b0;
            rd_q     <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            a_q      <= A;
            b_q      <= B;
            op_div_q <= op[1];
            rd_q     <= rd_i;
            cnt      <= '0;
            prod     <= {32'd0, B};
            rem      <= '0;
            quo      <= A;
            if (div_zero) begin
                HI   <= A;
                LO   <= '1;
                rd_o <= rd_i;
            end
        end else if (state == BUSY) begin
            cnt  <= cnt + 5'd1;
            prod <= prod_nxt;
            rem  <= rem_nxt;
            quo  <= quo_nxt;
            if (cnt == 5'd31) begin
                HI   <= op_div_q ? rem_nxt : prod_nxt[63:32];
                LO   <= op_div_q ? quo_nxt : prod_nxt[31:0];
                rd_o <= rd_q;
            end
        end
    end

endmodule
